// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-master (CPU/DMA) memory arbiter with DMA burst limit
module mem_arbiter #(
  parameter int unsigned DMA_MAX_BURST = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cpu_access,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [3:0]  cpu_we,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  input  logic        dma_req,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wdata,
  input  logic [3:0]  dma_we,
  output logic [31:0] dma_rdata,
  output logic        dma_ack,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_we,
  input  logic [31:0] mem_rdata,
  input  logic        mem_stall,
  output logic [1:0]  owner
);

  // State encoding doubles as the owner code: 00 idle, 01 CPU, 10 DMA.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CPU  = 2'b01,
    DMA  = 2'b10
  } state_t;

  localparam logic [3:0] MAX_BURST = 4'(DMA_MAX_BURST);

  state_t     state_q, state_d;
  logic [3:0] starve_cnt_q, starve_cnt_d;
  logic       cpu_starved;
  logic       done;

  // CPU has waited through the full DMA burst allowance and must win next.
  assign cpu_starved = cpu_access && (starve_cnt_q == MAX_BURST);
  assign done        = !mem_stall;

  // Next-state and starvation counter: one arbitration cycle in IDLE per access.
  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    case (state_q)
      IDLE: begin
        if (dma_req && !cpu_starved) begin
          state_d = DMA;
          if (cpu_access) starve_cnt_d = starve_cnt_q + 4'd1;
        end else if (cpu_access) begin
          state_d = CPU;
        end
        // Counter only tracks DMA wins that actually kept a waiting CPU out.
        if (!cpu_access || state_d == CPU) starve_cnt_d = 4'd0;
      end
      CPU: if (done) state_d = IDLE;
      DMA: if (done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register; reset aborts any in-flight access without completing it.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      starve_cnt_q <= 4'd0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  // Bus mux: drive the granted requester's access, zeros while idle.
  always_comb begin
    mem_addr  = 32'd0;
    mem_wdata = 32'd0;
    mem_we    = 4'd0;
    case (state_q)
      CPU: begin
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        mem_we    = cpu_we;
      end
      DMA: begin
        mem_addr  = dma_addr;
        mem_wdata = dma_wdata;
        mem_we    = dma_we;
      end
      default: ;
    endcase
  end

  assign owner     = state_q;
  assign cpu_stall = cpu_access && !(state_q == CPU && done);
  assign dma_ack   = (state_q == DMA) && done;
  assign cpu_rdata = mem_rdata;
  assign dma_rdata = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;

  logic        clock;
  logic        reset;
  logic        cpu_access;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [3:0]  cpu_we;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        dma_req;
  logic [31:0] dma_addr;
  logic [31:0] dma_wdata;
  logic [3:0]  dma_we;
  logic [31:0] dma_rdata;
  logic        dma_ack;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_we;
  logic [31:0] mem_rdata;
  logic        mem_stall;
  logic [1:0]  owner;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(.DMA_MAX_BURST(4)) dut (
    .clock      (clock),
    .reset      (reset),
    .cpu_access (cpu_access),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_we     (cpu_we),
    .cpu_rdata  (cpu_rdata),
    .cpu_stall  (cpu_stall),
    .dma_req    (dma_req),
    .dma_addr   (dma_addr),
    .dma_wdata  (dma_wdata),
    .dma_we     (dma_we),
    .dma_rdata  (dma_rdata),
    .dma_ack    (dma_ack),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .mem_rdata  (mem_rdata),
    .mem_stall  (mem_stall),
    .owner      (owner)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance to just after the next rising edge, where inputs are driven.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; cpu_access = 1'b0; dma_req = 1'b0; mem_stall = 1'b0;
    cpu_addr = 32'h0; cpu_wdata = 32'h0; cpu_we = 4'h0;
    dma_addr = 32'h0; dma_wdata = 32'h0; dma_we = 4'h0; mem_rdata = 32'h0;
    step(); step();
    #2;
    checks++; if (owner !== 2'b00) begin errors++; $display("FAIL reset_owner: got %b expected 00", owner); end
    checks++; if (mem_we !== 4'h0) begin errors++; $display("FAIL reset_mem_we: got %b expected 0000", mem_we); end
    checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL reset_mem_addr: got %h expected 0", mem_addr); end
    checks++; if (dma_ack !== 1'b0) begin errors++; $display("FAIL reset_dma_ack: got %b expected 0", dma_ack); end
    checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL reset_cpu_stall_lo: got %b expected 0", cpu_stall); end
    cpu_access = 1'b1; dma_req = 1'b1;
    #2;
    checks++; if (cpu_stall !== 1'b1) begin errors++; $display("FAIL reset_cpu_stall_hi: got %b expected 1", cpu_stall); end
    step();
    #2;
    checks++; if (owner !== 2'b00) begin errors++; $display("FAIL reset_hold_owner: got %b expected 00", owner); end
    cpu_access = 1'b0; dma_req = 1'b0;
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic test_idle();
    int bad;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      #2;
      checks++;
      if (owner !== 2'b00 || mem_addr !== 32'h0 || mem_wdata !== 32'h0 || mem_we !== 4'h0) begin
        errors++;
        $display("FAIL idle_outputs cycle %0d: owner=%b addr=%h wdata=%h we=%b expected all 0",
                 i, owner, mem_addr, mem_wdata, mem_we);
      end
      step();
    end
  endtask

  task automatic test_cpu_read();
    cpu_access = 1'b1; cpu_addr = 32'h4000_0010; cpu_wdata = 32'h1111_2222; cpu_we = 4'h0;
    mem_rdata = 32'hDEAD_BEEF; mem_stall = 1'b0;
    #2;
    checks++; if (cpu_stall !== 1'b1) begin errors++; $display("FAIL cpu_read_c0_stall: got %b expected 1", cpu_stall); end
    checks++; if (owner !== 2'b00) begin errors++; $display("FAIL cpu_read_c0_owner: got %b expected 00", owner); end
    step();
    #2;
    checks++; if (owner !== 2'b01) begin errors++; $display("FAIL cpu_read_c1_owner: got %b expected 01", owner); end
    checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL cpu_read_c1_stall: got %b expected 0", cpu_stall); end
    checks++; if (cpu_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL cpu_read_rdata: got %h expected deadbeef", cpu_rdata); end
    checks++; if (mem_addr !== 32'h4000_0010) begin errors++; $display("FAIL cpu_read_addr: got %h expected 40000010", mem_addr); end
    checks++; if (mem_we !== 4'h0) begin errors++; $display("FAIL cpu_read_we: got %b expected 0000", mem_we); end
    step();
    cpu_access = 1'b0;
    #2;
    checks++; if (owner !== 2'b00) begin errors++; $display("FAIL cpu_read_return_idle: got %b expected 00", owner); end
    step();
  endtask

  task automatic test_dma_write_stall();
    int acks;
    acks = 0;
    dma_req = 1'b1; dma_addr = 32'h0000_0A00; dma_we = 4'hF; dma_wdata = 32'h1234_5678; mem_stall = 1'b1;
    #2;
    checks++; if (owner !== 2'b00 || mem_we !== 4'h0) begin errors++; $display("FAIL dma_wr_arb: owner=%b we=%b expected 00/0000", owner, mem_we); end
    step();
    for (int i = 0; i < 4; i++) begin
      mem_stall = (i < 3);
      #2;
      checks++;
      if (owner !== 2'b10 || mem_we !== 4'hF || mem_wdata !== 32'h1234_5678) begin
        errors++;
        $display("FAIL dma_wr_hold cycle %0d: owner=%b we=%b wdata=%h expected 10/1111/12345678", i, owner, mem_we, mem_wdata);
      end
      if (dma_ack) acks++;
      checks++;
      if (dma_ack !== (i == 3)) begin errors++; $display("FAIL dma_wr_ack cycle %0d: got %b expected %b", i, dma_ack, (i == 3)); end
      step();
    end
    dma_req = 1'b0; mem_stall = 1'b0;
    #2;
    checks++; if (acks != 1) begin errors++; $display("FAIL dma_wr_ack_count: got %0d expected 1", acks); end
    checks++; if (owner !== 2'b00 || dma_ack !== 1'b0) begin errors++; $display("FAIL dma_wr_after: owner=%b ack=%b expected 00/0", owner, dma_ack); end
    step();
  endtask

  task automatic test_simultaneous();
    logic [1:0] grants [6];
    int acks_before_cpu;
    bit cpu_done;
    grants[0] = 2'b10; grants[1] = 2'b10; grants[2] = 2'b10;
    grants[3] = 2'b10; grants[4] = 2'b01; grants[5] = 2'b10;
    acks_before_cpu = 0;
    cpu_done = 1'b0;
    cpu_access = 1'b1; cpu_addr = 32'h100; cpu_we = 4'h0;
    dma_req = 1'b1; dma_addr = 32'h200; dma_we = 4'h0; mem_stall = 1'b0;
    for (int c = 0; c < 12; c++) begin
      #2;
      checks++;
      if (owner !== ((c % 2 == 0) ? 2'b00 : grants[c / 2])) begin
        errors++;
        $display("FAIL simul_owner cycle %0d: got %b expected %b", c, owner, (c % 2 == 0) ? 2'b00 : grants[c / 2]);
      end
      if (dma_ack && !cpu_done) acks_before_cpu++;
      if (owner == 2'b01 && !cpu_stall) cpu_done = 1'b1;
      step();
    end
    checks++; if (acks_before_cpu != 4) begin errors++; $display("FAIL simul_ack_count: got %0d expected 4", acks_before_cpu); end
    checks++; if (cpu_done !== 1'b1) begin errors++; $display("FAIL simul_cpu_done: got %b expected 1", cpu_done); end
    cpu_access = 1'b0; dma_req = 1'b0;
    step();
  endtask

  task automatic test_reset_mid_access();
    cpu_access = 1'b1; cpu_addr = 32'h300;
    dma_req = 1'b1; dma_addr = 32'h400; dma_we = 4'hF; mem_stall = 1'b1;
    step();
    #2;
    checks++; if (owner !== 2'b10) begin errors++; $display("FAIL rst_mid_first: got %b expected 10", owner); end
    checks++; if (dut.starve_cnt_q !== 4'd1) begin errors++; $display("FAIL rst_mid_starve_pre: got %0d expected 1", dut.starve_cnt_q); end
    step();
    reset = 1'b1;
    #2;
    checks++; if (owner !== 2'b10 || dma_ack !== 1'b0) begin errors++; $display("FAIL rst_mid_second: owner=%b ack=%b expected 10/0", owner, dma_ack); end
    step();
    reset = 1'b0; cpu_access = 1'b0; dma_req = 1'b0; mem_stall = 1'b0;
    #2;
    checks++; if (owner !== 2'b00) begin errors++; $display("FAIL rst_mid_owner: got %b expected 00", owner); end
    checks++; if (dma_ack !== 1'b0) begin errors++; $display("FAIL rst_mid_ack: got %b expected 0", dma_ack); end
    checks++; if (dut.starve_cnt_q !== 4'd0) begin errors++; $display("FAIL rst_mid_starve: got %0d expected 0", dut.starve_cnt_q); end
    step();
  endtask

  task automatic test_dma_pulses();
    logic [1:0] exp_owner [6];
    exp_owner[0] = 2'b00; exp_owner[1] = 2'b10; exp_owner[2] = 2'b00;
    exp_owner[3] = 2'b10; exp_owner[4] = 2'b00; exp_owner[5] = 2'b01;
    cpu_access = 1'b1; cpu_addr = 32'h500; mem_stall = 1'b0;
    dma_addr = 32'h600; dma_we = 4'h0;
    for (int c = 0; c < 6; c++) begin
      dma_req = (c < 4);
      #2;
      checks++;
      if (owner !== exp_owner[c]) begin errors++; $display("FAIL pulse_owner cycle %0d: got %b expected %b", c, owner, exp_owner[c]); end
      if (c == 4) begin
        checks++;
        if (dut.starve_cnt_q !== 4'd2) begin errors++; $display("FAIL pulse_starve_2: got %0d expected 2", dut.starve_cnt_q); end
      end
      if (c == 5) begin
        checks++;
        if (dut.starve_cnt_q !== 4'd0) begin errors++; $display("FAIL pulse_starve_clr: got %0d expected 0", dut.starve_cnt_q); end
        checks++;
        if (cpu_stall !== 1'b0) begin errors++; $display("FAIL pulse_cpu_done: got %b expected 0", cpu_stall); end
      end
      step();
    end
    cpu_access = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_idle();
    test_cpu_read();
    test_dma_write_stall();
    test_simultaneous();
    test_reset_mid_access();
    test_dma_pulses();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
